// File: rtl/pixel_shifter.sv
// -----------------------------------------------------------------------------
// pixel_shifter
//
// Takes 16-bit line-buffer words from the feeder and turns them into 1, 2 or
// 4 bpp pixel indices. Each index is looked up in a 16-entry, 12-bit RGB
// palette, and the result goes to the video DAC stage as registered colour
// plus a display enable. Everything runs on the dot clock.
//
// Pipeline, for a word captured at edge E:
//   E   : sh  <= word, en0 <= scanline_en_i
//   E+1 : pix_o <= index(sh), en1 <= en0
//   E+2 : rgb_o <= en1 ? pal[pix_o] : 0, de_o <= en1
//
// Ports:
//   dotclk_i       dot clock
//   rst_n_i        asynchronous active-low reset
//   scanline_en_i  high while a scanline is being refreshed
//   load_i         feeder load strobe; capture lb_dat_i on this edge
//   lb_dat_i       line-buffer word for the current fetch address
//   shift1_i       1bpp mode select
//   shift2_i       2bpp mode select
//   shift4_i       4bpp mode select (highest priority)
//   pal_we_i       palette write enable
//   pal_adr_i      palette write index
//   pal_dat_i      palette write data {R,G,B}
//   pix_o          stage-1 pixel index
//   rgb_o          stage-2 colour
//   de_o           display enable, aligned with rgb_o
// -----------------------------------------------------------------------------
module pixel_shifter (
    input  logic        dotclk_i,
    input  logic        rst_n_i,
    input  logic        scanline_en_i,
    input  logic        load_i,
    input  logic [15:0] lb_dat_i,
    input  logic        shift1_i,
    input  logic        shift2_i,
    input  logic        shift4_i,
    input  logic        pal_we_i,
    input  logic [3:0]  pal_adr_i,
    input  logic [11:0] pal_dat_i,
    output logic [3:0]  pix_o,
    output logic [11:0] rgb_o,
    output logic        de_o
);

    typedef enum logic [1:0] {
        MODE_1BPP,
        MODE_2BPP,
        MODE_4BPP
    } mode_t;

    mode_t       mode;
    logic [15:0] sh;
    logic [15:0] sh_next;
    logic [3:0]  cur_idx;
    logic        en0;
    logic        en1;
    logic [11:0] pal [16];

    // When no mode input is set, the shifter runs as 1bpp.
    always_comb begin
        if (shift4_i) begin
            mode = MODE_4BPP;
        end else if (shift2_i) begin
            mode = MODE_2BPP;
        end else begin
            mode = MODE_1BPP;
        end
    end

    // The mode is applied combinationally on every edge. A mode change in the
    // middle of a word therefore affects the next shift only; the bits left
    // in sh are not realigned.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        cur_idx = {3'b000, sh[15]};
        sh_next = {sh[14:0], 1'b0};
        case (mode)
            MODE_2BPP: begin
                cur_idx = {2'b00, sh[15:14]};
                sh_next = {sh[13:0], 2'b00};
            end
            MODE_4BPP: begin
                cur_idx = sh[15:12];
                sh_next = {sh[11:0], 4'b0000};
            end
            default: ;
        endcase
        // A load replaces the shift. A premature load cuts the current word short.
        if (load_i) begin
            sh_next = lb_dat_i;
        end
    end

    // Shift register and the display-enable / colour pipeline.
    always_ff @(posedge dotclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sh    <= 16'h0000;
            en0   <= 1'b0;
            en1   <= 1'b0;
            pix_o <= 4'h0;
            rgb_o <= 12'h000;
            de_o  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every stage sample the
            // value it held before this edge, which is what keeps the
            // pipeline stages one clock apart.
            sh    <= sh_next;
            en0   <= scanline_en_i;
            pix_o <= cur_idx;
            en1   <= en0;
            rgb_o <= en1 ? pal[pix_o] : 12'h000;
            de_o  <= en1;
        end
    end

    // Palette. A stage-2 read of an entry that is written on the same edge
    // returns the old contents.
    always_ff @(posedge dotclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            // NOTE: this storage is reset on purpose, because its power-up
            // contents (a grey ramp) are visible behaviour. Storage whose
            // initial contents do not matter would be left unreset.
            for (int i = 0; i < 16; i++) begin
                pal[i] <= {4'(i), 4'(i), 4'(i)};
            end
        end else if (pal_we_i) begin
            pal[pal_adr_i] <= pal_dat_i;
        end
    end

endmodule

// File: tb/tb_pixel_shifter.sv
// -----------------------------------------------------------------------------
// tb_pixel_shifter
//
// Testbench for pixel_shifter. Inputs are driven on the falling edge of the
// dot clock. For each directed vector, the stimulus pushes the expected
// {de, rgb} together with the edge number at which that value should appear.
// A monitor on the falling edge pops each entry when its edge comes round and
// compares it with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_pixel_shifter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        scanline_en = 1'b0;
    logic        load = 1'b0;
    logic [15:0] lb_dat = 16'h0000;
    logic        shift1 = 1'b0;
    logic        shift2 = 1'b0;
    logic        shift4 = 1'b0;
    logic        pal_we = 1'b0;
    logic [3:0]  pal_adr = 4'h0;
    logic [11:0] pal_dat = 12'h000;
    logic [3:0]  pix;
    logic [11:0] rgb;
    logic        de;

    pixel_shifter dut (
        .dotclk_i      (clk),
        .rst_n_i       (rst_n),
        .scanline_en_i (scanline_en),
        .load_i        (load),
        .lb_dat_i      (lb_dat),
        .shift1_i      (shift1),
        .shift2_i      (shift2),
        .shift4_i      (shift4),
        .pal_we_i      (pal_we),
        .pal_adr_i     (pal_adr),
        .pal_dat_i     (pal_dat),
        .pix_o         (pix),
        .rgb_o         (rgb),
        .de_o          (de)
    );

    always #5 clk = ~clk;

    // Number of rising edges seen so far.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic        de;
        logic [11:0] rgb;
        string       name;
    } exp_t;

    exp_t        sb[$];
    logic [11:0] seq [16];
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, req, cyc);
        end
    endtask

    task automatic expect_out(input int c, input logic d, input logic [11:0] r, input string name);
        exp_t e;
        e.cyc  = c;
        e.de   = d;
        e.rgb  = r;
        e.name = name;
        sb.push_back(e);
    endtask

    // Push seq[0..n-1] as displayed pixels on consecutive edges, starting at
    // edge 'start'.
    task automatic push_seq(input int start, input int n, input string name);
        for (int k = 0; k < n; k++) begin
            expect_out(start + k, 1'b1, seq[k], $sformatf("%s[%0d]", name, k));
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Monitor: compares every expectation at the edge it was scheduled for.
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL %s: expectation for edge %0d not compared (now %0d)", e.name, e.cyc, cyc);
        end
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            check({e.name, ".de"}, {15'd0, de}, {15'd0, e.de});
            check({e.name, ".rgb"}, {4'd0, rgb}, {4'd0, e.rgb});
        end
    end

    initial begin
        int n;
        int r;
        int k;

        // State while reset is held.
        #12;
        check("reset.pix", {12'd0, pix}, 16'h0000);
        check("reset.rgb", {4'd0, rgb}, 16'h0000);
        check("reset.de", {15'd0, de}, 16'h0000);

        tick();
        rst_n = 1'b1;
        scanline_en = 1'b1;
        shift1 = 1'b1;
        tick();
        pal_we = 1'b1;
        pal_adr = 4'd1;
        pal_dat = 12'hFFF;
        tick();
        pal_we = 1'b0;
        tick();
        tick();

        // 1bpp with pal[1]=FFF, then a reload that lands seamlessly on pixel 17.
        n = cyc;
        load = 1'b1;
        lb_dat = 16'hA5F0;
        seq = '{12'hFFF, 12'h000, 12'hFFF, 12'h000, 12'h000, 12'hFFF, 12'h000, 12'hFFF,
                12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'h000, 12'h000, 12'h000, 12'h000};
        push_seq(n + 3, 16, "bpp1_a5f0");
        tick();
        load = 1'b0;
        wait_cyc(n + 16);
        load = 1'b1;
        lb_dat = 16'h8001;
        seq = '{12'hFFF, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000,
                12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'hFFF};
        push_seq(n + 19, 16, "bpp1_8001");
        tick();
        load = 1'b0;
        wait_cyc(n + 36);

        // Palette write collision: pal[3] <= F00 on the edge of the stage-2 read.
        shift1 = 1'b0;
        shift4 = 1'b1;
        tick();
        n = cyc;
        load = 1'b1;
        lb_dat = 16'h3003;
        expect_out(n + 3, 1'b1, 12'h333, "collide_old");
        expect_out(n + 4, 1'b1, 12'h000, "collide_p1");
        expect_out(n + 5, 1'b1, 12'h000, "collide_p2");
        expect_out(n + 6, 1'b1, 12'hF00, "collide_new");
        tick();
        load = 1'b0;
        tick();
        pal_we = 1'b1;
        pal_adr = 4'd3;
        pal_dat = 12'hF00;
        tick();
        pal_we = 1'b0;
        wait_cyc(n + 8);

        // Asynchronous reset in the middle of the stream.
        shift4 = 1'b0;
        shift1 = 1'b1;
        tick();
        n = cyc;
        load = 1'b1;
        lb_dat = 16'hFFFF;
        expect_out(n + 3, 1'b1, 12'hFFF, "prereset");
        tick();
        load = 1'b0;
        wait_cyc(n + 4);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset.pix", {12'd0, pix}, 16'h0000);
        check("midreset.rgb", {4'd0, rgb}, 16'h0000);
        check("midreset.de", {15'd0, de}, 16'h0000);
        tick();
        tick();

        // Release while the scanline is active. The 4bpp word reads the grey ramp.
        rst_n = 1'b1;
        shift1 = 1'b0;
        shift4 = 1'b1;
        load = 1'b1;
        lb_dat = 16'h0F85;
        r = cyc;
        expect_out(r + 1, 1'b0, 12'h000, "release_e1");
        expect_out(r + 2, 1'b0, 12'h000, "release_e2");
        seq[0] = 12'h000;
        seq[1] = 12'hFFF;
        seq[2] = 12'h888;
        seq[3] = 12'h555;
        push_seq(r + 3, 4, "ramp_0f85");
        tick();
        load = 1'b0;
        wait_cyc(r + 8);

        // 2bpp on the reset palette, with a reload on the 8th pixel.
        shift4 = 1'b0;
        shift2 = 1'b1;
        tick();
        n = cyc;
        load = 1'b1;
        lb_dat = 16'h1B00;
        seq = '{12'h000, 12'h111, 12'h222, 12'h333, 12'h000, 12'h000, 12'h000, 12'h000,
                12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000};
        push_seq(n + 3, 8, "bpp2_1b00");
        tick();
        load = 1'b0;
        wait_cyc(n + 8);
        load = 1'b1;
        lb_dat = 16'hE400;
        seq[0] = 12'h333;
        seq[1] = 12'h222;
        seq[2] = 12'h111;
        seq[3] = 12'h000;
        push_seq(n + 11, 4, "bpp2_e400");
        tick();
        load = 1'b0;
        wait_cyc(n + 16);

        // Blanking: scanline_en drops before edge n+6, so outputs blank from edge n+8.
        shift2 = 1'b0;
        shift1 = 1'b1;
        tick();
        n = cyc;
        load = 1'b1;
        lb_dat = 16'hFFFF;
        for (int i = 3; i <= 7; i++) begin
            expect_out(n + i, 1'b1, 12'h111, $sformatf("blank_on[%0d]", i));
        end
        expect_out(n + 8, 1'b0, 12'h000, "blank_off0");
        expect_out(n + 9, 1'b0, 12'h000, "blank_off1");
        tick();
        load = 1'b0;
        wait_cyc(n + 5);
        scanline_en = 1'b0;

        // A load during blanking still updates sh.
        wait_cyc(n + 12);
        shift1 = 1'b0;
        shift4 = 1'b1;
        load = 1'b1;
        lb_dat = 16'h0A00;
        k = cyc;
        expect_out(k + 3, 1'b0, 12'h000, "blankload_off");
        expect_out(k + 4, 1'b1, 12'hAAA, "blankload_on");
        tick();
        load = 1'b0;
        scanline_en = 1'b1;
        wait_cyc(k + 8);

        // A load on a shift edge wins: the second word shows up unshifted.
        n = cyc;
        load = 1'b1;
        lb_dat = 16'h1234;
        seq[0] = 12'h111;
        seq[1] = 12'h555;
        seq[2] = 12'h666;
        seq[3] = 12'h777;
        seq[4] = 12'h888;
        push_seq(n + 3, 5, "loadprio");
        tick();
        lb_dat = 16'h5678;
        tick();
        load = 1'b0;
        wait_cyc(n + 10);

        // Mode priority: shift1 and shift4 both set gives 4bpp.
        shift1 = 1'b1;
        shift4 = 1'b1;
        n = cyc;
        load = 1'b1;
        lb_dat = 16'h0F85;
        seq[0] = 12'h000;
        seq[1] = 12'hFFF;
        seq[2] = 12'h888;
        seq[3] = 12'h555;
        push_seq(n + 3, 4, "modeprio");
        tick();
        load = 1'b0;

        // Drain the scoreboard, with a bounded wait.
        for (int i = 0; i < 50 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations never compared, required 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
